led_scan_controller: RTL and testbench

- Time-multiplexed scan controller for an 8-digit common-segment 7-segment display.
- Holds a 32-bit hex value and an 8-bit decimal-point mask, and lights one digit at a time, each for a programmable dwell.
- Inserts a blank gap between digits to suppress ghosting.
- Accepts new display data through a ready/valid handshake and commits it only at a frame boundary, so a frame never mixes old and new data.

---
 rtl/led_scan_if.sv | 24 ++
 rtl/led_scan_controller.sv | 203 ++++++++++++++++++++
 tb/tb_led_scan_controller.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/led_scan_if.sv
// Load handshake, scan enable and display drive signals of the LED scan controller.
interface led_scan_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    en;
  logic                    loadValid;
  logic [4*NUM_DIGITS-1:0] loadData;
  logic [NUM_DIGITS-1:0]   loadDp;
  logic                    loadReady;
  logic                    loadDone;
  logic [NUM_DIGITS-1:0]   digitSel;
  logic [7:0]              segOut;
  logic                    frameStart;

  modport master (
    output en, loadValid, loadData, loadDp,
    input  loadReady, loadDone, digitSel, segOut, frameStart
  );

  modport slave (
    input  en, loadValid, loadData, loadDp,
    output loadReady, loadDone, digitSel, segOut, frameStart
  );
endinterface

// File: rtl/led_scan_controller.sv
// Time-multiplexed 7-segment scan controller; new data commits only at a frame boundary.
// Leading-zero blanking is built when LED_SCAN_ZERO_BLANK_EN is defined.
module led_scan_controller #(
  parameter int NUM_DIGITS   = 8,
  parameter int DWELL_CYCLES = 1000,
  parameter int GAP_CYCLES   = 16
) (
  input  logic      clk,
  input  logic      rst,
  led_scan_if.slave bus
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (DWELL_CYCLES > GAP_CYCLES)
                           ? ((DWELL_CYCLES > 2) ? DWELL_CYCLES : 2)
                           : ((GAP_CYCLES   > 2) ? GAP_CYCLES   : 2);
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int DATA_W  = 4 * NUM_DIGITS;
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_SHOW = 2'd0,
    ST_GAP  = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     disp_data_q, disp_data_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic [DATA_W-1:0]     pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_full_q, pend_full_d;
  logic                  dark_q, dark_d;

  logic                  dwell_done;
  logic                  gap_done;
  logic                  frame_end;
  logic                  commit;
  logic [IDX_W-1:0]      idx_wrap;
  logic                  lit;
  logic [3:0]            cur_nibble;
  logic [6:0]            glyph;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h27;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h58;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Scan position decode; all of it depends on registered state only.
  assign dwell_done = (state_q == ST_SHOW) && (cnt_q == DWELL_LAST);
  assign gap_done   = HAS_GAP && (state_q == ST_GAP) && (cnt_q == GAP_LAST);
  assign frame_end  = (HAS_GAP ? gap_done : dwell_done) && (idx_q == IDX_LAST);
  assign idx_wrap   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
  assign commit     = pend_full_q && !dark_q && (frame_end || (state_q == ST_OFF));

  always_comb begin
    // NOTE: every variable written here gets its default first, so no path can infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    disp_data_d = disp_data_q;
    disp_dp_d   = disp_dp_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;
    dark_d      = 1'b0;

    // The cycle after reset release stays dark with the scan frozen at digit 0.
    if (!dark_q) begin
      if (!bus.en) begin
        state_d = ST_OFF;
        idx_d   = '0;
        cnt_d   = '0;
      end else begin
        case (state_q)
          ST_SHOW: begin
            if (dwell_done) begin
              cnt_d = '0;
              if (HAS_GAP) state_d = ST_GAP;
              else         idx_d   = idx_wrap;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          ST_GAP: begin
            if (gap_done) begin
              cnt_d   = '0;
              state_d = ST_SHOW;
              idx_d   = idx_wrap;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_d = ST_SHOW;
            idx_d   = '0;
            cnt_d   = '0;
          end
        endcase
      end
    end

    // A commit cycle shows loadReady low, so it can never coincide with an accept.
    if (commit) begin
      disp_data_d = pend_data_q;
      disp_dp_d   = pend_dp_q;
      pend_full_d = 1'b0;
    end else if (bus.loadValid && !pend_full_q) begin
      pend_data_d = bus.loadData;
      pend_dp_d   = bus.loadDp;
      pend_full_d = 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SHOW;
      idx_q       <= '0;
      cnt_q       <= '0;
      disp_data_q <= '0;
      disp_dp_q   <= '0;
      pend_full_q <= 1'b0;
      dark_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      disp_data_q <= disp_data_d;
      disp_dp_q   <= disp_dp_d;
      pend_full_q <= pend_full_d;
      dark_q      <= dark_d;
    end
  end

  // NOTE: the pending payload is deliberately not reset; pend_full_q alone says whether it is valid.
  always_ff @(posedge clk) begin
    pend_data_q <= pend_data_d;
    pend_dp_q   <= pend_dp_d;
  end

  assign lit        = !dark_q && (state_q == ST_SHOW);
  assign cur_nibble = disp_data_q[{idx_q, 2'b00} +: 4];

`ifdef LED_SCAN_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_mask;
  logic                  upper_zero;

  // Digit i blanks when it and every more significant nibble are zero; digit 0 never blanks.
  always_comb begin
    upper_zero = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero    = upper_zero & (disp_data_q[4*i +: 4] == 4'h0);
      blank_mask[i] = upper_zero;
    end
  end

  assign glyph = blank_mask[idx_q] ? 7'h00 : hex_to_seg(cur_nibble);
`else
  assign glyph = hex_to_seg(cur_nibble);
`endif

  assign bus.digitSel   = lit ? (NUM_DIGITS'(1) << idx_q) : '0;
  assign bus.segOut     = lit ? {disp_dp_q[idx_q], glyph} : 8'h00;
  assign bus.frameStart = lit && (idx_q == '0) && (cnt_q == '0);
  assign bus.loadDone   = commit;
  assign bus.loadReady  = !pend_full_q;

  a_sel_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(bus.digitSel));

  a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_GAP) ? (cnt_q <= GAP_LAST) : (cnt_q <= DWELL_LAST));

  a_done_needs_data: assert property (@(posedge clk) disable iff (rst)
    bus.loadDone |-> !bus.loadReady);

endmodule

// File: tb/tb_led_scan_controller.sv
// Randomized scoreboard bench for led_scan_controller against a frame-time reference model.
module tb_led_scan_controller;

  localparam int N     = 8;
  localparam int DW    = 4;
  localparam int GP    = 2;
  localparam int PER   = DW + GP;
  localparam int FRAME = N * PER;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_scan_if #(.NUM_DIGITS(N)) bus ();

  led_scan_controller #(
    .NUM_DIGITS  (N),
    .DWELL_CYCLES(DW),
    .GAP_CYCLES  (GP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [N-1:0] sel;
    logic [7:0]   seg;
    logic         fs;
    logic         done;
    logic         rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71};

  // Reference model: position in the frame as a plain cycle count.
  bit          m_dark = 1'b1;
  bit          m_on   = 1'b1;
  int          m_t    = 0;
  logic [31:0] m_disp = '0;
  logic [7:0]  m_ddp  = '0;
  logic [31:0] m_pend = '0;
  logic [7:0]  m_pdp  = '0;
  bit          m_full = 1'b0;
  bit          m_acc  = 1'b0;
  exp_t        m_exp  = '0;

  // Inputs applied during the current cycle, consumed by the model at the next edge.
  bit          a_rst  = 1'b1;
  bit          a_en   = 1'b0;
  bit          a_lv   = 1'b0;
  logic [31:0] a_data = '0;
  logic [7:0]  a_dp   = '0;

  function automatic bit digit_blank(input int d);
    logic [31:0] upper;
    bit          b;
    upper = m_disp >> (4 * d);
    b     = (d > 0) && (upper == 32'h0);
`ifdef LED_SCAN_ZERO_BLANK_EN
    return b;
`else
    return b & 1'b0;
`endif
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int   d;
    int   ph;
    e     = '0;
    e.rdy = !m_full;
    if (m_dark) return e;
    if (!m_on) begin
      e.done = m_full;
      return e;
    end
    d  = m_t / PER;
    ph = m_t % PER;
    if (ph < DW) begin
      e.sel      = N'(1) << d;
      e.seg[7]   = m_ddp[d];
      e.seg[6:0] = digit_blank(d) ? 7'h00 : seg_tab[m_disp[4*d +: 4]];
    end
    e.fs   = (m_t == 0);
    e.done = m_full && (m_t == FRAME - 1);
    return e;
  endfunction

  task automatic model_step();
    bit commit;
    if (a_rst) begin
      m_dark = 1'b1;
      m_on   = 1'b1;
      m_t    = 0;
      m_disp = '0;
      m_ddp  = '0;
      m_full = 1'b0;
      return;
    end
    commit = m_exp.done;
    if (m_dark)         m_dark = 1'b0;
    else if (!a_en)     begin m_on = 1'b0; m_t = 0; end
    else if (!m_on)     begin m_on = 1'b1; m_t = 0; end
    else                m_t = (m_t + 1) % FRAME;
    if (commit) begin
      m_disp = m_pend;
      m_ddp  = m_pdp;
      m_full = 1'b0;
    end else if (a_lv && !m_full) begin
      m_pend = a_data;
      m_pdp  = a_dp;
      m_full = 1'b1;
      m_acc  = 1'b1;
    end
  endtask

  // One clock: advance the model, queue this cycle's expected outputs, then drive new inputs.
  task automatic cycle(input bit r, input bit e, input bit lv,
                       input logic [31:0] dat, input logic [7:0] dp);
    @(posedge clk);
    #1;
    model_step();
    m_exp = model_out();
    exp_q.push_back(m_exp);
    a_rst = r; a_en = e; a_lv = lv; a_data = dat; a_dp = dp;
    rst           = r;
    bus.en        = e;
    bus.loadValid = lv;
    bus.loadData  = dat;
    bus.loadDp    = dp;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0, 8'h00);
  endtask

  task automatic hold_load(input logic [31:0] dat, input logic [7:0] dp);
    int guard;
    guard = 0;
    m_acc = 1'b0;
    do begin
      cycle(1'b0, 1'b1, 1'b1, dat, dp);
      guard++;
    end while (!m_acc && guard < 4 * FRAME);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: the DUT presents a fresh output set every cycle; compare mid-cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("digitSel",   32'(bus.digitSel),   32'(e.sel));
        check("segOut",     32'(bus.segOut),     32'(e.seg));
        check("frameStart", 32'(bus.frameStart), 32'(e.fs));
        check("loadDone",   32'(bus.loadDone),   32'(e.done));
        check("loadReady",  32'(bus.loadReady),  32'(e.rdy));
      end
    end
  end

  initial begin : stim
    bit          en_r;
    bit          r;
    bit          lv;
    logic [31:0] dat;
    int          guard;

    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.loadValid = 1'b0;
    bus.loadData  = '0;
    bus.loadDp    = '0;

    // Reset release, free-running scan, load near cycle 10, held second load near cycle 20.
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 8'h00);
    idle(10);
    cycle(1'b0, 1'b1, 1'b1, 32'h89AB_CDEF, 8'h01);
    idle(9);
    hold_load(32'h1234_5678, 8'h80);
    idle(2 * FRAME);

    // Scan disabled with a full pending buffer: immediate commit while dark.
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 8'h00);
    idle(8);
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0120, 8'h04);
    idle(4);
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
    idle(2 * FRAME);

    // Reset in the gap after digit 5 while a load is pending.
    cycle(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 8'hFF);
    guard = 0;
    while (!(m_on && m_t == 5 * PER + DW) && guard < 2 * FRAME) begin
      idle(1);
      guard++;
    end
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 8'h00);
    idle(FRAME + 4);

    // Randomized traffic: loads, enable drops, occasional resets.
    en_r = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 1999) == 0);
      if (en_r && $urandom_range(0, 199) == 0)       en_r = 1'b0;
      else if (!en_r && $urandom_range(0, 9) == 0)   en_r = 1'b1;
      lv  = ($urandom_range(0, 5) == 0);
      dat = $urandom;
      dat = dat >> $urandom_range(0, 32);
      cycle(r, en_r, lv, dat, 8'($urandom));
    end
    idle(2);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
